// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encoding,
// default latencies, FSM state type and the start classification.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_md_start(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// E-stage MDU bus: request side driven by the pipeline, status/result side
// driven by the scheduler.
interface mdu_scheduler_if;
    logic [3:0]  op_E;
    logic [31:0] a_E;
    logic [31:0] b_E;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] rdata_E;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_E, a_E, b_E, md_use_D,
        input  start, busy, stall, rdata_E, hi, lo
    );

    modport slave (
        input  op_E, a_E, b_E, md_use_D,
        output start, busy, stall, rdata_E, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the full {hi,lo} result
// for the op in E; the scheduler latches it at the start edge.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        div_zero_o
);

    logic signed [63:0] sa, sb;
    logic [31:0]        b_nz;
    logic               ovf;
    logic [31:0]        sq, sr, uq, ur;

    assign sa   = {{32{a_i[31]}}, a_i};
    assign sb   = {{32{b_i[31]}}, b_i};
    // Divisor forced non-zero so the divider never sees x/0; the result is
    // discarded anyway when div_zero_o is set.
    assign b_nz = (b_i == 32'd0) ? 32'd1 : b_i;
    // Most-negative / -1 overflows 32 bits; its defined answer is handled apart.
    assign ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    assign sq = ovf ? 32'h8000_0000 : 32'($signed(a_i) / $signed(b_nz));
    assign sr = ovf ? 32'd0         : 32'($signed(a_i) % $signed(b_nz));
    assign uq = a_i / b_nz;
    assign ur = a_i % b_nz;

    // Select the result for the requested op.
    always_comb begin
        res_o      = 64'd0;
        div_zero_o = 1'b0;
        case (op_i)
            OP_MULT:  res_o = sa * sb;
            OP_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
            OP_DIV: begin
                res_o      = {sr, sq};
                div_zero_o = (b_i == 32'd0);
            end
            OP_DIVU: begin
                res_o      = {ur, uq};
                div_zero_o = (b_i == 32'd0);
            end
            default: res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_scheduler.sv
// Multi-cycle MDU scheduler: runs MULT/DIV for a fixed latency, then commits
// to HI/LO. Raises stall while an MDU op waits in D behind a busy unit.
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mdu_scheduler_if.slave bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);

    mdu_state_e    state_q;
    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi_q, pend_lo_q;
    logic          pend_dz_q;

    logic          start;
    logic          is_mul;
    logic [63:0]   res;
    logic          div_zero;

    assign start  = is_md_start(bus.op_E);
    assign is_mul = (bus.op_E == OP_MULT) || (bus.op_E == OP_MULTU);

    mdu_arith u_arith (
        .op_i       (bus.op_E),
        .a_i        (bus.a_E),
        .b_i        (bus.b_E),
        .res_o      (res),
        .div_zero_o (div_zero)
    );

    // FSM: accept ops in IDLE, count down in RUN, commit on the last cycle.
    // Ops arriving while RUN are ignored (the stall keeps them out).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi_q <= res[63:32];
                        pend_lo_q <= res[31:0];
                        pend_dz_q <= div_zero;
                        cnt_q     <= is_mul ? MUL_LD : DIV_LD;
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                    end else if (bus.op_E == OP_MTHI) begin
                        hi_q <= bus.a_E;
                    end else if (bus.op_E == OP_MTLO) begin
                        lo_q <= bus.a_E;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start   = start;
    assign bus.busy    = busy_q;
    assign bus.stall   = bus.md_use_D & (start | busy_q);
    assign bus.rdata_E = (bus.op_E == OP_MFHI) ? hi_q :
                         (bus.op_E == OP_MFLO) ? lo_q : 32'd0;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed scenarios followed by random traffic,
// all outputs compared every cycle against a cycle-count reference model.
module tb_mdu_scheduler;
    import mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk;
    logic reset;
    mdu_scheduler_if bus ();

    mdu_scheduler #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference state: architectural HI/LO, cycles of busy remaining and
    // the result waiting to land when that count runs out.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pv = 1'b0;
    int          m_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl, output bit ok);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        ok = 1'b1;
        case (op)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    logic [63:0] uq, ur;
                    uq = ua / ub;
                    ur = ua % ub;
                    p  = {ur[31:0], uq[31:0]};
                end
            end
            default: ok = 1'b0;
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    // One pipeline cycle: drive, check all outputs mid-cycle, clock, advance model.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic rst);
        logic        e_start;
        logic [31:0] e_rd;
        bus.op_E     = op;
        bus.a_E      = a;
        bus.b_E      = b;
        bus.md_use_D = use_d;
        reset        = rst;
        #1;
        e_start = (op >= OP_MULT) && (op <= OP_DIVU);
        e_rd    = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        chk("start", 32'(bus.start), 32'(e_start));
        chk("busy",  32'(bus.busy),  32'(m_left > 0));
        chk("stall", 32'(bus.stall), 32'(use_d && (e_start || m_left > 0)));
        chk("rdata", bus.rdata_E, e_rd);
        chk("hi",    bus.hi, m_hi);
        chk("lo",    bus.lo, m_lo);
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pv = 0; m_phi = 0; m_plo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pv) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (e_start) begin
            ref_calc(op, a, b, m_phi, m_plo, m_pv);
            m_left = (op <= OP_MULTU) ? MUL_N : DIV_N;
        end else if (op == OP_MTHI) begin
            m_hi = a;
        end else if (op == OP_MTLO) begin
            m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) step(OP_NONE, $urandom, $urandom, use_d, 1'b0);
    endtask

    // The stall must keep every MDU op out of E while the unit is busy.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.busy === 1'b1)
            chk("proto", 32'((bus.op_E >= OP_MULT) && (bus.op_E <= OP_MFLO)), 32'd0);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b1;
        bus.op_E = OP_NONE; bus.a_E = 0; bus.b_E = 0; bus.md_use_D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with combinational outputs following live inputs.
        step(OP_MFHI, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);

        // Signed multiply -3 * 5.
        step(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        idle(MUL_N, 1'b0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

        // Unsigned then signed divide.
        step(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("divu_hi", bus.hi, 32'd1);
        chk("divu_lo", bus.lo, 32'd3);
        step(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);

        // MULTU max*max with an MDU op held in D, then MFHI reaches E.
        step(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle(MUL_N, 1'b1);
        step(OP_MFHI, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        // MTHI then MFHI in the very next cycle.
        step(OP_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        step(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mthi_hi", bus.hi, 32'h1234_5678);

        // Overflowing signed divide.
        step(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);

        // Divide by zero runs the full period but leaves HI/LO alone.
        step(OP_MTHI, 32'hAA, 32'd0, 1'b0, 1'b0);
        step(OP_MTLO, 32'hBB, 32'd0, 1'b0, 1'b0);
        step(OP_DIV, 32'd99, 32'd0, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("dz_hi", bus.hi, 32'hAA);
        chk("dz_lo", bus.lo, 32'hBB);

        // Reset in the 3rd busy cycle discards the multiply.
        step(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(10, 1'b0);
        chk("rstrun_hi", bus.hi, 32'd0);
        chk("rstrun_lo", bus.lo, 32'd0);

        // Random traffic; MDU ops only offered while the model is idle.
        for (int i = 0; i < 500; i++) begin
            op = (m_left > 0) ? OP_NONE : 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 15))
                0, 1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multi-cycle multiply/divide scheduler with HI/LO for the five-stage pipeline. It accepts MDU operations from the Execute stage and runs them for a fixed latency, then commits the results to HI/LO. While an operation is in flight, it raises a stall request so the hazard logic holds any MDU instruction in Decode. It sits beside the ALU in Execute, and its stall output is ORed into the existing stall/clear path (F/D hold, E clear).

## Interface
- MUL_CYCLES, default 5, busy cycles for MULT/MULTU.
- DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- op_E  in  4  decoded MDU op of the instruction in E; mdu_pkg encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; values 9–15 are treated as NONE.
- a_E  in  32  forwarded rs value in E.
- b_E  in  32  forwarded rt value in E.
- md_use_D  in  1  instruction in D is any MDU op (MULT..MFLO).
- start  out  1  combinational; high when op_E ∈ {MULT, MULTU, DIV, DIVU}.
- busy  out  1  registered; operation in flight.
- stall  out  1  combinational; md_use_D & (start | busy).
- rdata_E  out  32  combinational; HI when op_E=MFHI, LO when op_E=MFLO, else 0.
- hi, lo  out  32  architectural HI/LO registers.

## Operation
- Two states: IDLE (busy=0) and RUN (busy=1). A down-counter cnt holds the remaining cycles (width sized for max(MUL_CYCLES, DIV_CYCLES)).
- IDLE, start=1:
  - latch the full result into pend_hi/pend_lo; results are computed from a_E and b_E at the start edge;
  - load cnt with MUL_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN:
  - decrement cnt each cycle;
  - when cnt reaches 1, the edge writes HI←pend_hi, LO←pend_lo and returns to IDLE.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. DIVU: unsigned quotient and remainder.
- DIV with 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU with b=0):
  - the full busy period still runs;
  - HI/LO are left unchanged (the commit is suppressed).
- MTHI/MTLO in IDLE: HI←a_E or LO←a_E at the edge; busy stays 0.
- MFHI/MFLO: combinational read through rdata_E; no state change.
- op_E other than NONE while busy=1 is a protocol violation, because stall prevents it. The bench asserts it never occurs; the RTL ignores such ops (no restart, no HI/LO write).
- reset: busy=0, cnt=0, HI=LO=0, pend_hi=pend_lo=0. An operation in flight is discarded.
- Reset values of outputs:
  - busy=0, hi=0, lo=0;
  - start, stall and rdata_E follow their inputs.

## Timing
- An op in E at cycle T (start=1) gives busy=1 in cycles T+1 .. T+N, where N = MUL_CYCLES or DIV_CYCLES.
- The new HI/LO are visible from T+N+1, the same cycle busy=0.
- stall=1 in T if md_use_D; stall=1 in T+1 .. T+N if md_use_D. An MFHI held in D therefore reaches E at T+N+1 or later and reads the committed value.
- A back-to-back MDU op in D is released in T+N+1 and reaches E in T+N+2.
- MTHI/MTLO take effect at the next edge: an MFHI in E in the following cycle reads the new value, with no forwarding needed.
- A non-MDU instruction never stalls. Pipeline flow continues while busy.
- reset during RUN: busy=0 on the next edge; no commit occurs.

## Structure
- mdu_pkg holds:
  - op encoding localparams (NONE..MFLO);
  - default MUL_CYCLES/DIV_CYCLES;
  - the is_md_start() classification function.
- Sub-module mdu_arith (combinational): takes op, a and b; returns the 64-bit {hi,lo} result and a div_zero flag.
- mdu_scheduler holds the FSM, counter, pending registers, HI/LO and the stall logic.
- The top level ORs stall into T_Stop and drives rdata_E into the E-stage result mux.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5; md_use_D=0 → busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU a=7, b=2, then DIV a=0xFFFFFFF9 (−7), b=2 → first result HI=1, LO=3 after 10 cycles; second result HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- MULTU a=b=0xFFFFFFFF with md_use_D=1 held throughout → stall=1 for cycles T..T+5 and 0 at T+6; then HI=0xFFFFFFFE, LO=0x00000001, and an MFHI in E at T+6 gives rdata_E=0xFFFFFFFE.
- MTHI a=0x12345678, then MFHI in E in the next cycle → rdata_E=0x12345678; busy stays 0 and stall=0.
- DIV with b=0, HI=0xAA and LO=0xBB beforehand → busy for 10 cycles; HI=0xAA and LO=0xBB unchanged afterwards.
- MULT 3×4, then reset asserted at the 3rd busy cycle → busy=0, HI=LO=0 on the next edge; no later commit (HI/LO stay 0 for 10 more cycles).
